// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse message scheduler.
// Queue entries carry a letter code plus an end-of-word flag.
package morse_pkg;

    localparam int CODE_W = 6;
    localparam logic [CODE_W-1:0] MAX_CODE = 6'd35;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DRAIN
    } state_e;

    typedef struct packed {
        logic              word_end;
        logic [CODE_W-1:0] code;
    } entry_t;

    function automatic logic code_valid(input logic [CODE_W-1:0] c);
        return c <= MAX_CODE;
    endfunction

endpackage

// File: rtl/morse_sched_fifo.sv
// Synchronous letter queue with occupancy count, full flag and flush.
// Pointers wrap naturally because the depth is a power of two.
module morse_sched_fifo
    import morse_pkg::*;
#(
    parameter int P_DEPTH = 8,
    localparam int AW = $clog2(P_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        wr_data_i,
    output entry_t        rd_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    entry_t        mem_q [P_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o    = (count_q == CW'(P_DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign push_ok   = push_i && !full_o && !flush_i;
    assign pop_ok    = pop_i && (count_q != '0) && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/morse_msg_scheduler.sv
// Queues letters and feeds them one at a time to a Morse generator
// using a start/busy handshake, with abort and streaming append.
module morse_msg_scheduler
    import morse_pkg::*;
#(
    parameter int P_DEPTH = 8,
    localparam int CW = $clog2(P_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [CODE_W-1:0] wr_code_i,
    input  logic              wr_word_end_i,
    input  logic              go_i,
    input  logic              abort_i,
    input  logic              gen_busy_i,
    output logic [CODE_W-1:0] gen_letter_code_o,
    output logic              gen_letter_space_o,
    output logic              gen_word_space_o,
    output logic              gen_start_o,
    output logic              full_o,
    output logic [CW-1:0]     count_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              ls_q, ls_d;
    logic              ws_q, ws_d;
    logic              err_q, err_d;
    logic              push, pop, done;
    logic              head_ls;
    entry_t            head, wr_entry;

    assign wr_entry = '{word_end: wr_word_end_i, code: wr_code_i};
    assign push     = wr_en_i && !abort_i && !full_o
                      && code_valid(wr_code_i);
    assign err_d    = wr_en_i && !abort_i
                      && (full_o || !code_valid(wr_code_i));

    morse_sched_fifo #(.P_DEPTH(P_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (abort_i),
        .wr_data_i (wr_entry),
        .rd_data_o (head),
        .count_o   (count_o),
        .full_o    (full_o)
    );

    // The last queued letter of an unfinished word gets no trailing gap.
    assign head_ls = !((count_o == CW'(1)) && !head.word_end);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ls_d    = ls_q;
        ws_d    = ws_q;
        pop     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go_i && count_o != '0) state_d = S_START;
            end
            S_START: begin
                code_d  = head.code;
                ls_d    = head_ls;
                ws_d    = head.word_end;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (gen_busy_i) begin
                    pop     = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!gen_busy_i) begin
                    if (count_o != '0) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!gen_busy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_DRAIN;
            pop     = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            ls_q    <= 1'b0;
            ws_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ls_q    <= ls_d;
            ws_q    <= ws_d;
            err_q   <= err_d;
        end
    end

    // Request fields come live from the head in START and are frozen
    // in WAIT_ACK so appends cannot disturb an unacknowledged letter.
    always_comb begin
        gen_start_o        = 1'b0;
        gen_letter_code_o  = '0;
        gen_letter_space_o = 1'b0;
        gen_word_space_o   = 1'b0;
        unique case (state_q)
            S_START: begin
                gen_start_o        = 1'b1;
                gen_letter_code_o  = head.code;
                gen_letter_space_o = head_ls;
                gen_word_space_o   = head.word_end;
            end
            S_WAIT_ACK: begin
                gen_start_o        = 1'b1;
                gen_letter_code_o  = code_q;
                gen_letter_space_o = ls_q;
                gen_word_space_o   = ws_q;
            end
            default: ;
        endcase
    end

    assign err_o  = err_q;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done;

endmodule

// File: tb/tb_morse_msg_scheduler.sv
// Directed bench for the Morse message scheduler; a small inline
// generator model answers start requests with a busy pulse.
module tb_morse_msg_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en_i;
    logic [5:0] wr_code_i;
    logic       wr_word_end_i;
    logic       go_i;
    logic       abort_i;
    logic       gen_busy_i;
    logic [5:0] gen_letter_code_o;
    logic       gen_letter_space_o;
    logic       gen_word_space_o;
    logic       gen_start_o;
    logic       full_o;
    logic [3:0] count_o;
    logic       err_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    morse_msg_scheduler #(.P_DEPTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .wr_en_i            (wr_en_i),
        .wr_code_i          (wr_code_i),
        .wr_word_end_i      (wr_word_end_i),
        .go_i               (go_i),
        .abort_i            (abort_i),
        .gen_busy_i         (gen_busy_i),
        .gen_letter_code_o  (gen_letter_code_o),
        .gen_letter_space_o (gen_letter_space_o),
        .gen_word_space_o   (gen_word_space_o),
        .gen_start_o        (gen_start_o),
        .full_o             (full_o),
        .count_o            (count_o),
        .err_o              (err_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [5:0] c, input logic we);
        wr_en_i       = 1'b1;
        wr_code_i     = c;
        wr_word_end_i = we;
        tick();
        wr_en_i       = 1'b0;
    endtask

    task automatic pulse_go();
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    // Waits (bounded) for a start request, checks it, then plays busy.
    task automatic gen_respond(input logic [5:0] c, input logic ls,
                               input logic ws);
        int n = 0;
        while (gen_start_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (gen_start_o !== 1'b1) begin
            errors++;
            $display("FAIL start_timeout got %b want 1", gen_start_o);
        end
        checks++;
        if (gen_letter_code_o !== c) begin
            errors++;
            $display("FAIL letter_code got %0d want %0d",
                     gen_letter_code_o, c);
        end
        checks++;
        if (gen_letter_space_o !== ls) begin
            errors++;
            $display("FAIL letter_space code %0d got %b want %b",
                     c, gen_letter_space_o, ls);
        end
        checks++;
        if (gen_word_space_o !== ws) begin
            errors++;
            $display("FAIL word_space code %0d got %b want %b",
                     c, gen_word_space_o, ws);
        end
        gen_busy_i = 1'b1;
        tick();
        tick();
        tick();
        gen_busy_i = 1'b0;
        #1;
        if (done_o === 1'b1) done_seen++;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy_o, count_o, full_o, err_o, done_o, gen_start_o}
            !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs busy %b count %0d full %b start %b",
                     busy_o, count_o, full_o, gen_start_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        done_seen = 0;
        wr(6'd0, 1'b0);
        wr(6'd1, 1'b0);
        wr(6'd2, 1'b1);
        checks++;
        if (count_o !== 4'd3) begin
            errors++;
            $display("FAIL basic_count got %0d want 3", count_o);
        end
        pulse_go();
        gen_respond(6'd0, 1'b1, 1'b0);
        gen_respond(6'd1, 1'b1, 1'b0);
        gen_respond(6'd2, 1'b1, 1'b1);
        checks++;
        if (done_seen != 1) begin
            errors++;
            $display("FAIL basic_done got %0d want 1", done_seen);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 7; i++) wr(6'(i), 1'b0);
        checks++;
        if (full_o !== 1'b0) begin
            errors++;
            $display("FAIL full_after7 got %b want 0", full_o);
        end
        wr(6'd7, 1'b1);
        checks++;
        if (full_o !== 1'b1 || count_o !== 4'd8) begin
            errors++;
            $display("FAIL full_after8 full %b count %0d want 1 8",
                     full_o, count_o);
        end
        wr(6'd8, 1'b0);
        checks++;
        if (err_o !== 1'b1 || count_o !== 4'd8) begin
            errors++;
            $display("FAIL full_reject err %b count %0d want 1 8",
                     err_o, count_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle got %b want 0", err_o);
        end
        pulse_abort();
        checks++;
        if (count_o !== 4'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort count %0d busy %b want 0 0",
                     count_o, busy_o);
        end
    endtask

    task automatic test_bad_code();
        do_reset();
        wr(6'd40, 1'b0);
        checks++;
        if (err_o !== 1'b1 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL bad_code err %b count %0d want 1 0",
                     err_o, count_o);
        end
        pulse_go();
        checks++;
        if (busy_o !== 1'b0 || gen_start_o !== 1'b0) begin
            errors++;
            $display("FAIL go_empty busy %b start %b want 0 0",
                     busy_o, gen_start_o);
        end
        wr(6'd35, 1'b0);
        checks++;
        if (err_o !== 1'b0 || count_o !== 4'd1) begin
            errors++;
            $display("FAIL code35 err %b count %0d want 0 1",
                     err_o, count_o);
        end
        abort_i = 1'b1;
        wr(6'd50, 1'b0);
        abort_i = 1'b0;
        checks++;
        if (err_o !== 1'b0 || count_o !== 4'd0) begin
            errors++;
            $display("FAIL abort_prio err %b count %0d want 0 0",
                     err_o, count_o);
        end
    endtask

    task automatic test_abort();
        do_reset();
        done_seen = 0;
        wr(6'd5, 1'b0);
        wr(6'd6, 1'b0);
        wr(6'd7, 1'b0);
        wr(6'd8, 1'b1);
        pulse_go();
        gen_respond(6'd5, 1'b1, 1'b0);
        checks++;
        if (gen_start_o !== 1'b1 || gen_letter_code_o !== 6'd6) begin
            errors++;
            $display("FAIL second_letter start %b code %0d want 1 6",
                     gen_start_o, gen_letter_code_o);
        end
        gen_busy_i = 1'b1;
        tick();
        tick();
        pulse_abort();
        checks++;
        if (count_o !== 4'd0 || busy_o !== 1'b1 || gen_start_o !== 1'b0)
        begin
            errors++;
            $display("FAIL abort count %0d busy %b start %b want 0 1 0",
                     count_o, busy_o, gen_start_o);
        end
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold busy %b done %b want 1 0",
                     busy_o, done_o);
        end
        gen_busy_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_done got %b want 0", done_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit busy %b done %b want 0 0",
                     busy_o, done_o);
        end
    endtask

    task automatic test_stall_stream();
        int bad = 0;
        do_reset();
        done_seen = 0;
        wr(6'd9, 1'b0);
        pulse_go();
        for (int i = 0; i < 20; i++) begin
            if (gen_start_o !== 1'b1 || gen_letter_code_o !== 6'd9 ||
                gen_letter_space_o !== 1'b0 || count_o !== 4'd1)
                bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold bad_cycles got %0d want 0", bad);
        end
        gen_busy_i    = 1'b1;
        wr_en_i       = 1'b1;
        wr_code_i     = 6'd10;
        wr_word_end_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        checks++;
        if (count_o !== 4'd1 || gen_start_o !== 1'b0) begin
            errors++;
            $display("FAIL push_pop count %0d start %b want 1 0",
                     count_o, gen_start_o);
        end
        gen_busy_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_early_done got %b want 0", done_o);
        end
        tick();
        gen_respond(6'd10, 1'b1, 1'b1);
        checks++;
        if (done_seen != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_done done %0d busy %b want 1 0",
                     done_seen, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(6'd11, 1'b0);
        wr(6'd12, 1'b0);
        wr(6'd13, 1'b0);
        wr(6'd14, 1'b1);
        pulse_go();
        gen_busy_i = 1'b1;
        tick();
        tick();
        checks++;
        if (count_o !== 4'd3 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup count %0d busy %b want 3 1",
                     count_o, busy_o);
        end
        do_reset();
        checks++;
        if ({gen_start_o, gen_letter_code_o, gen_letter_space_o,
             gen_word_space_o, full_o, count_o, err_o, busy_o, done_o}
            !== 17'b0) begin
            errors++;
            $display("FAIL mid_reset start %b code %0d count %0d busy %b",
                     gen_start_o, gen_letter_code_o, count_o, busy_o);
        end
        gen_busy_i = 1'b0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        wr_en_i       = 1'b0;
        wr_code_i     = '0;
        wr_word_end_i = 1'b0;
        go_i          = 1'b0;
        abort_i       = 1'b0;
        gen_busy_i    = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_full();
        test_bad_code();
        test_abort();
        test_stall_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
